// File: rtl/packet_serializer.sv
// -----------------------------------------------------------------------------
// packet_serializer
//
// Turns one accepted request into a fixed-length serial frame:
//   8-bit preamble 8'hA5 (MSB first), then a 256-bit body, then GAP_BITS idle zeros.
// Body layout (bit k goes out on the k-th body cycle):
//   0..63    zero
//   64..79   port_num, MSB first
//   80..135  zero
//   136..143 session_id, MSB first
//   144..255 pseudo-random payload from a free-running 16-bit Fibonacci LFSR
//            (taps 16,14,13,11). The LFSR advances only on payload bits and
//            keeps its state from one packet to the next.
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous, active-low reset
//   in_valid     request to send one packet
//   in_ready     high only while IDLE; accept = in_valid && in_ready
//   port_num     16-bit destination port, captured at acceptance
//   session_id   8-bit session number, captured at acceptance
//   serial_out   registered serial bit stream
//   frame_active high while preamble or body bits are on serial_out
//   pkt_done     one-cycle pulse with the last body bit
//   pkt_cnt      completed-packet counter, wraps at 2^32
// -----------------------------------------------------------------------------
module packet_serializer #(
    parameter int unsigned GAP_BITS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] port_num,
    input  logic [7:0]  session_id,
    output logic        serial_out,
    output logic        frame_active,
    output logic        pkt_done,
    output logic [31:0] pkt_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        BODY,
        GAP
    } state_t;

    localparam logic [7:0]  PREAMBLE_PAT = 8'hA5;
    localparam logic [15:0] LFSR_SEED    = 16'hACE1;
    localparam logic [8:0]  PRE_LAST     = 9'd7;
    localparam logic [8:0]  BODY_LAST    = 9'd255;
    localparam logic [8:0]  GAP_LAST     = 9'(GAP_BITS - 1);
    localparam logic [8:0]  PORT_FIRST   = 9'd64;
    localparam logic [8:0]  PORT_END     = 9'd80;
    localparam logic [8:0]  SESS_FIRST   = 9'd136;
    localparam logic [8:0]  PAYLOAD_FIRST = 9'd144;

    state_t      state, state_n;
    logic [8:0]  bit_cnt, bit_cnt_n;   // index of the bit currently on the line within its phase
    logic [15:0] port_q;
    logic [7:0]  sess_q;
    logic [15:0] lfsr;
    logic        accept;
    logic        serial_n;
    logic        lfsr_step;
    logic        lfsr_fb;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid && in_ready;
    assign lfsr_fb  = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    // Next-state logic. state/bit_cnt describe the bit on serial_out in the
    // current cycle, so the *_n values describe the bit loaded at this edge.
    // NOTE: every variable written in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt + 9'd1;
        unique case (state)
            IDLE: begin
                bit_cnt_n = '0;
                if (accept) state_n = PREAMBLE;
            end
            PREAMBLE: begin
                if (bit_cnt == PRE_LAST) begin
                    state_n   = BODY;
                    bit_cnt_n = '0;
                end
            end
            BODY: begin
                if (bit_cnt == BODY_LAST) begin
                    state_n   = GAP;
                    bit_cnt_n = '0;
                end
            end
            GAP: begin
                if (bit_cnt == GAP_LAST) begin
                    state_n   = IDLE;
                    bit_cnt_n = '0;
                end
            end
            default: begin
                state_n   = IDLE;
                bit_cnt_n = '0;
            end
        endcase
    end

    // Bit to be placed on serial_out at this edge. Within each field the low
    // counter bits run 0..N-1, so MSB-first selection is just their inverse.
    always_comb begin
        serial_n  = 1'b0;
        lfsr_step = 1'b0;
        unique case (state_n)
            PREAMBLE: serial_n = PREAMBLE_PAT[~bit_cnt_n[2:0]];
            BODY: begin
                if (bit_cnt_n >= PAYLOAD_FIRST) begin
                    serial_n  = lfsr[15];
                    lfsr_step = 1'b1;
                end else if (bit_cnt_n >= SESS_FIRST) begin
                    serial_n = sess_q[~bit_cnt_n[2:0]];
                end else if (bit_cnt_n >= PORT_FIRST && bit_cnt_n < PORT_END) begin
                    serial_n = port_q[~bit_cnt_n[3:0]];
                end
            end
            default: serial_n = 1'b0;
        endcase
    end

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            port_q       <= '0;
            sess_q       <= '0;
            lfsr         <= LFSR_SEED;
            serial_out   <= 1'b0;
            frame_active <= 1'b0;
            pkt_done     <= 1'b0;
            pkt_cnt      <= '0;
        end else begin
            state        <= state_n;
            bit_cnt      <= bit_cnt_n;
            serial_out   <= serial_n;
            frame_active <= (state_n == PREAMBLE) || (state_n == BODY);
            pkt_done     <= (state_n == BODY) && (bit_cnt_n == BODY_LAST);
            if (accept) begin
                port_q <= port_num;
                sess_q <= session_id;
            end
            if (lfsr_step) lfsr <= {lfsr[14:0], lfsr_fb};
            // Counted on the edge that ends the last body cycle.
            if (state == BODY && bit_cnt == BODY_LAST) pkt_cnt <= pkt_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_packet_serializer.sv
// -----------------------------------------------------------------------------
// tb_packet_serializer
//
// Self-checking bench for packet_serializer (GAP_BITS = 8).
// Accepted requests push one expected record per output cycle into a queue;
// a negedge monitor pops and compares serial_out / frame_active / pkt_done /
// in_ready / pkt_cnt, and expects idle values whenever the queue is empty.
// A small table of packets plus hand-written sequences cover back-to-back
// traffic, mid-frame reset and counter wrap.
// -----------------------------------------------------------------------------
module tb_packet_serializer;

    localparam int          GAP     = 8;
    localparam int          PKT_LEN = 264 + GAP;   // output cycles T+1 .. T+264+GAP
    localparam logic [7:0]  PRE     = 8'hA5;
    localparam logic [15:0] SEED    = 16'hACE1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] port_num;
    logic [7:0]  session_id;
    logic        serial_out;
    logic        frame_active;
    logic        pkt_done;
    logic [31:0] pkt_cnt;

    always #5 clk = ~clk;

    packet_serializer #(.GAP_BITS(GAP)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .port_num     (port_num),
        .session_id   (session_id),
        .serial_out   (serial_out),
        .frame_active (frame_active),
        .pkt_done     (pkt_done),
        .pkt_cnt      (pkt_cnt)
    );

    typedef struct {
        bit          s;
        bit          f;
        bit          d;
        int          pos;
        logic [31:0] cnt;
    } exp_t;

    typedef struct {
        logic [15:0] port;
        logic [7:0]  sess;
        bit          chg;
        logic [15:0] exp_port;
        logic [7:0]  exp_sess;
    } vec_t;

    exp_t        exp_q[$];
    exp_t        pe;
    exp_t        me;
    int          pk;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          mon_en = 0;
    bit          prev_ready = 1;
    logic [15:0] m_lfsr = SEED;
    logic [31:0] m_cnt = '0;
    int          acc_count = 0;
    int          acc_cyc = 0;
    int          acc_list[$];
    int          done_cyc = 0;
    int          done_seen = 0;
    int          ready_cyc = 0;
    logic [255:0] body_cap = '0;
    vec_t        vecs[3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    // 16 reference payload bits after skipping 'skip' steps from the seed.
    function automatic logic [31:0] ref_bits(input int skip);
        logic [15:0] l = SEED;
        logic [31:0] r = '0;
        for (int i = 0; i < skip; i++) l = lfsr_next(l);
        for (int i = 0; i < 16; i++) begin
            r = {r[30:0], l[15]};
            l = lfsr_next(l);
        end
        return r;
    endfunction

    // Captured body bits lo..lo+n-1 assembled MSB first.
    function automatic logic [31:0] field(input int lo, input int n);
        logic [31:0] r = '0;
        for (int k = lo; k < lo + n; k++) r = {r[30:0], body_cap[k]};
        return r;
    endfunction

    // Acceptance detector and scoreboard producer.
    always @(posedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            m_lfsr = SEED;
            m_cnt  = '0;
        end else if (in_valid && in_ready) begin
            acc_count++;
            acc_cyc = cyc;
            acc_list.push_back(cyc);
            for (int p = 0; p < PKT_LEN; p++) begin
                pe.pos = p;
                pe.f   = (p < 264);
                pe.d   = (p == 263);
                pe.cnt = (p < 264) ? m_cnt : m_cnt + 32'd1;
                pe.s   = 1'b0;
                if (p < 8) begin
                    pe.s = PRE[7 - p];
                end else if (p < 264) begin
                    pk = p - 8;
                    if (pk >= 64 && pk < 80)        pe.s = port_num[79 - pk];
                    else if (pk >= 136 && pk < 144) pe.s = session_id[143 - pk];
                    else if (pk >= 144) begin
                        pe.s   = m_lfsr[15];
                        m_lfsr = lfsr_next(m_lfsr);
                    end
                end
                exp_q.push_back(pe);
            end
            m_cnt = m_cnt + 32'd1;
        end
    end

    // Monitor: compares outputs once per cycle, away from the active edge.
    always @(negedge clk) begin
        cyc++;
        if (mon_en) begin
            if (pkt_done === 1'b1) begin
                done_seen++;
                done_cyc = cyc;
            end
            if (in_ready === 1'b1 && !prev_ready) ready_cyc = cyc;
            prev_ready = (in_ready === 1'b1);
            if (exp_q.size() > 0) begin
                me = exp_q.pop_front();
                check("serial_out",   32'(serial_out),   32'(me.s));
                check("frame_active", 32'(frame_active), 32'(me.f));
                check("pkt_done",     32'(pkt_done),     32'(me.d));
                check("in_ready_busy", 32'(in_ready),    32'd0);
                check("pkt_cnt",      pkt_cnt,           me.cnt);
                if (me.pos >= 8 && me.pos < 264) body_cap[me.pos - 8] = serial_out;
            end else begin
                check("idle_serial_out",   32'(serial_out),   32'd0);
                check("idle_frame_active", 32'(frame_active), 32'd0);
                check("idle_pkt_done",     32'(pkt_done),     32'd0);
                check("idle_in_ready",     32'(in_ready),     32'd1);
                check("idle_pkt_cnt",      pkt_cnt,           m_cnt);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        repeat (n) tick();
        rst_n = 1'b1;
    endtask

    // Returns one cycle after the acceptance edge (cycle T+1).
    task automatic send(input logic [15:0] p, input logic [7:0] s);
        int  start = acc_count;
        bit  ok = 0;
        port_num   = p;
        session_id = s;
        in_valid   = 1'b1;
        for (int i = 0; i < 600; i++) begin
            tick();
            if (acc_count != start) begin
                ok = 1;
                break;
            end
        end
        in_valid = 1'b0;
        check("accept_timeout", 32'(ok), 32'd1);
    endtask

    // Waits until the frame has drained and one extra cycle for the monitor.
    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (in_ready === 1'b1 && exp_q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        tick();
        check("idle_timeout", 32'(ok), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (got running, expected done)");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int n;

        vecs[0] = '{16'h01BB, 8'h3C, 1'b1, 16'h01BB, 8'h3C};
        vecs[1] = '{16'hFFFF, 8'h00, 1'b0, 16'hFFFF, 8'h00};
        vecs[2] = '{16'h8001, 8'hA5, 1'b0, 16'h8001, 8'hA5};

        // Reset with in_valid asserted: nothing may be accepted.
        rst_n      = 1'b0;
        in_valid   = 1'b1;
        port_num   = 16'h0;
        session_id = 8'h0;
        repeat (3) tick();
        in_valid = 1'b0;
        rst_n    = 1'b1;
        mon_en   = 1;
        check("reset_pkt_cnt",   pkt_cnt,            32'd0);
        check("reset_in_ready",  32'(in_ready),      32'd1);
        check("reset_serial",    32'(serial_out),    32'd0);
        check("reset_frame",     32'(frame_active),  32'd0);
        check("reset_no_accept", 32'(acc_count),     32'd0);

        // Table-driven single packets.
        for (int i = 0; i < 3; i++) begin
            send(vecs[i].port, vecs[i].sess);
            if (vecs[i].chg) begin
                repeat (4) tick();           // now in cycle T+5
                port_num = 16'h5B67;
            end
            wait_idle();
            check("port_field",    field(64, 16),        32'(vecs[i].exp_port));
            check("session_field", field(136, 8),        32'(vecs[i].exp_sess));
            check("pkt_cnt_after", pkt_cnt,              32'(i + 1));
            check("done_latency",  32'(done_cyc - acc_cyc),  32'd264);
            check("ready_latency", 32'(ready_cyc - acc_cyc), 32'(265 + GAP));
            if (i == 0) check("first_payload_bit", 32'(body_cap[144]), 32'd1);
            if (i < 2)  check("payload_lfsr", field(144, 16), ref_bits(i * 112));
        end

        // in_valid held high: three back-to-back packets.
        do_reset(1);
        port_num   = 16'h1234;
        session_id = 8'h56;
        in_valid   = 1'b1;
        d0 = acc_count;
        for (int i = 0; i < 1200; i++) begin
            tick();
            if (acc_count == d0 + 3) break;
        end
        in_valid = 1'b0;
        check("b2b_accepts", 32'(acc_count - d0), 32'd3);
        n = acc_list.size();
        if (n >= 3) begin
            check("b2b_period_1", 32'(acc_list[n-2] - acc_list[n-3]), 32'(265 + GAP));
            check("b2b_period_2", 32'(acc_list[n-1] - acc_list[n-2]), 32'(265 + GAP));
        end
        wait_idle();
        check("b2b_pkt_cnt", pkt_cnt, 32'd3);

        // Reset one cycle at T+100 abandons the frame.
        d0 = done_seen;
        send(16'h01BB, 8'h3C);
        repeat (99) tick();                  // now in cycle T+100
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;                        // now in cycle T+101
        check("abort_serial",  32'(serial_out),   32'd0);
        check("abort_frame",   32'(frame_active), 32'd0);
        check("abort_pkt_cnt", pkt_cnt,           32'd0);
        repeat (300) tick();
        check("abort_no_done", 32'(done_seen - d0), 32'd0);
        send(16'h01BB, 8'h3C);
        wait_idle();
        check("abort_next_pkt_cnt", pkt_cnt,       32'd1);
        check("abort_next_port",    field(64, 16), 32'h01BB);

        // Counter wrap.
        force dut.pkt_cnt = 32'hFFFF_FFFF;
        m_cnt = 32'hFFFF_FFFF;
        tick();
        release dut.pkt_cnt;
        check("wrap_preload", pkt_cnt, 32'hFFFF_FFFF);
        d0 = done_seen;
        send(16'h0042, 8'h07);
        wait_idle();
        check("wrap_pkt_cnt", pkt_cnt,                 32'd0);
        check("wrap_done",    32'(done_seen - d0),     32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/packet_serializer.md
PACKET_SERIALIZER -- requirements
Module: packet_serializer

Interface
REQ-001 SHALL have parameter GAP_BITS, default 8, the number of idle-zero bits sent after each packet body (legal range 1..255).
REQ-002 SHALL have clk  input  1  clock; all state changes on the rising edge.
REQ-003 SHALL have rst_n  input  1  reset: synchronous, active-low; clock clk.
REQ-004 SHALL have in_valid  input  1  request to send one packet.
REQ-005 SHALL have in_ready  output  1  high only in IDLE; a packet is accepted on any edge where in_valid && in_ready.
REQ-006 SHALL have port_num  input  16  destination port, sampled at acceptance.
REQ-007 SHALL have session_id  input  8  session number, sampled at acceptance.
REQ-008 SHALL have serial_out  output  1  registered serial bit stream.
REQ-009 SHALL have frame_active  output  1  high while preamble or body bits are on serial_out.
REQ-010 SHALL have pkt_done  output  1  one-cycle pulse in the cycle the last body bit is on serial_out.
REQ-011 SHALL have pkt_cnt  output  32  number of completed packets.

Function
REQ-012 SHALL implement FSM states IDLE, PREAMBLE, BODY and GAP; transitions are IDLE->PREAMBLE on acceptance, PREAMBLE->BODY after 8 bits, BODY->GAP after 256 bits, and GAP->IDLE after GAP_BITS bits.
REQ-013 SHALL latch port_num and session_id on the acceptance edge; input changes after acceptance have no effect on the packet in flight.
REQ-014 SHALL, for acceptance at edge of cycle T, drive preamble 8'hA5 MSB-first on serial_out in cycles T+1..T+8.
REQ-015 SHALL drive body bit k (k=0..255) on serial_out in cycle T+9+k.
REQ-016 SHALL drive body bits 64..79 with port_num MSB-first (bit 64 = port_num[15]).
REQ-017 SHALL drive body bits 136..143 with session_id MSB-first (bit 136 = session_id[7]).
REQ-018 SHALL drive body bits 144..255 from lfsr[15] of a 16-bit Fibonacci LFSR (taps 16,14,13,11; shift left, feedback into bit 0); the LFSR advances once per payload bit only and retains its state across packets.
REQ-019 SHALL drive all other body bits (0..63, 80..135) as 0.
REQ-020 SHALL drive serial_out = 0 in IDLE and in GAP; GAP occupies cycles T+265..T+264+GAP_BITS.
REQ-021 SHALL return to IDLE (in_ready=1) in cycle T+265+GAP_BITS; with in_valid held high, the packet period is 265+GAP_BITS cycles.
REQ-022 SHALL ignore in_valid while in_ready=0; no queuing, and the request is accepted only once in_ready rises.
REQ-023 SHALL hold frame_active=1 exactly in cycles T+1..T+264.
REQ-024 SHALL assert pkt_done only in cycle T+264.
REQ-025 SHALL make pkt_cnt increment on the edge ending cycle T+264 (new value visible from T+265) and wrap from 32'hFFFFFFFF to 0.
REQ-026 SHALL count bits with a 9-bit counter; every FSM boundary is an exact compare, with no off-by-one across the preamble/body/gap edges.

Reset
REQ-027 SHALL, on rst_n=0 at a clock edge, set state=IDLE, serial_out=0, frame_active=0, pkt_done=0, pkt_cnt=0, bit counter=0, latched fields=0 and lfsr=16'hACE1; in_ready=1 from the first cycle after reset.
REQ-028 SHALL abandon an in-flight packet on reset mid-frame: serial_out=0 from the next cycle, no pkt_done, pkt_cnt=0.
REQ-029 SHALL not accept a packet on an edge where rst_n=0, even if in_valid=1.

Verification
REQ-030 SHALL cover: single packet with port_num=16'h01BB, session_id=8'h3C, GAP_BITS=8 -> serial_out T+1..T+8 = 1,0,1,0,0,1,0,1; body bits 64..79 = 0000000110111011; bits 136..143 = 00111100; pkt_done at T+264; pkt_cnt=1 at T+265; in_ready=1 at T+273.
REQ-031 SHALL cover: payload after reset -> bits 144..159 match a reference-model LFSR seeded 16'hACE1 (first bit 1); a second packet's payload continues the sequence with no reseed.
REQ-032 SHALL cover: in_valid held high for 3 packets, GAP_BITS=8 -> acceptances exactly 273 cycles apart; pkt_cnt=3; serial_out=0 in every gap cycle.
REQ-033 SHALL cover: port_num changed to 16'h5B67 at T+5 -> transmitted port field still 16'h01BB.
REQ-034 SHALL cover: rst_n=0 for one cycle at T+100 -> serial_out=0, frame_active=0, pkt_cnt=0 from T+101; no pkt_done; next acceptance sends a fresh 8'hA5 preamble.
REQ-035 SHALL cover: pkt_cnt forced to 32'hFFFFFFFF then one packet completed -> pkt_cnt=0 with a single pkt_done pulse.
